// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg: shared definitions for stream_fifo_thr.
//   cnt_width(depth) - width of a counter holding 0..depth (at least 1 bit)
//   STATS_CNT_W      - width of the optional handshake counters
//   stats_t          - push/pop handshake counter pair
package stream_fifo_pkg;

  localparam int STATS_CNT_W = 32;

  typedef struct packed {
    logic [STATS_CNT_W-1:0] push_cnt;
    logic [STATS_CNT_W-1:0] pop_cnt;
  } stats_t;

  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_fifo_thr_if.sv
// stream_fifo_thr_if: valid/ready stream bundle.
//   data  - payload of type T
//   valid - producer has a beat
//   ready - consumer takes the beat
// Modports: master drives data/valid, slave drives ready.
interface stream_fifo_thr_if #(
  parameter type T = logic [31:0]
);
  T     data;
  logic valid;
  logic ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/stream_fifo_ptr.sv
// stream_fifo_ptr: pointer that wraps from DEPTH-1 back to 0 (any DEPTH >= 1).
//   clk_i - clock          rst_i - synchronous active-high reset
//   clr_i - synchronous clear to 0
//   inc_i - advance by one
//   ptr_o - current pointer value
module stream_fifo_ptr #(
  parameter int DEPTH = 8,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs from before the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      ptr_o <= '0;
    end else if (inc_i) begin
      ptr_o <= (ptr_o == PTR_W'(DEPTH - 1)) ? '0 : ptr_o + PTR_W'(1);
    end
  end

endmodule

// File: rtl/stream_fifo_thr.sv
// stream_fifo_thr: valid/ready FIFO with usage count, programmable
// almost-full/almost-empty flags, arbitrary depth and DEPTH=0 pass-through.
//   clk_i          - clock, rising edge
//   rst_i          - synchronous active-high reset
//   flush_i        - synchronous clear of all entries (overrides push/pop)
//   usage_o        - stored entries, 0..DEPTH
//   almost_full_o  - usage_o >= AF_THRESH
//   almost_empty_o - usage_o <= AE_THRESH
//   in_if          - input stream (slave)
//   out_if         - output stream (master)
// Optional (macro STREAM_FIFO_THR_STATS_EN):
//   push_cnt_o/pop_cnt_o - wrapping handshake counts, cleared by rst_i only
//   hwm_o                - peak usage, cleared by rst_i and flush_i
module stream_fifo_thr
  import stream_fifo_pkg::*;
#(
  parameter bit  FALL_THROUGH = 1'b0,
  parameter int  DATA_WIDTH   = 32,
  parameter int  DEPTH        = 8,
  parameter type T            = logic [DATA_WIDTH-1:0],
  parameter int  AF_THRESH    = DEPTH - 1,
  parameter int  AE_THRESH    = 1,
  localparam int CNT_WIDTH    = cnt_width(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  output logic [CNT_WIDTH-1:0] usage_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  stream_fifo_thr_if.slave     in_if,
  stream_fifo_thr_if.master    out_if
`ifdef STREAM_FIFO_THR_STATS_EN
  ,
  output logic [STATS_CNT_W-1:0] push_cnt_o,
  output logic [STATS_CNT_W-1:0] pop_cnt_o,
  output logic [CNT_WIDTH-1:0]   hwm_o
`endif
);

  if (AF_THRESH > DEPTH || AE_THRESH > DEPTH) begin : g_bad_thresh
    $error("stream_fifo_thr: AF_THRESH/AE_THRESH must not exceed DEPTH");
  end
  if (DEPTH > 0 && AE_THRESH >= AF_THRESH) begin : g_bad_order
    $error("stream_fifo_thr: AE_THRESH must be below AF_THRESH");
  end

  if (DEPTH == 0) begin : g_pass
    assign in_if.ready    = out_if.ready;
    assign out_if.valid   = in_if.valid;
    assign out_if.data    = in_if.data;
    assign usage_o        = '0;
    assign almost_full_o  = (0 >= AF_THRESH);
    assign almost_empty_o = (0 <= AE_THRESH);
`ifdef STREAM_FIFO_THR_STATS_EN
    stats_t stats_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stats_q <= '0;
      end else if (in_if.valid && out_if.ready) begin
        stats_q.push_cnt <= stats_q.push_cnt + STATS_CNT_W'(1);
        stats_q.pop_cnt  <= stats_q.pop_cnt + STATS_CNT_W'(1);
      end
    end
    assign push_cnt_o = stats_q.push_cnt;
    assign pop_cnt_o  = stats_q.pop_cnt;
    assign hwm_o      = '0;
`endif
  end else begin : g_fifo
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                     mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_WIDTH-1:0] usage_q, usage_nxt;
    logic                 empty, push, pop, bypass, wr_en, rd_en;

    assign empty        = (usage_q == '0);
    assign in_if.ready  = (usage_q != CNT_WIDTH'(DEPTH));
    assign out_if.valid = !empty || (FALL_THROUGH && in_if.valid);
    assign out_if.data  = (FALL_THROUGH && empty) ? in_if.data : mem[rd_ptr];

    assign push   = in_if.valid && in_if.ready;
    assign pop    = out_if.valid && out_if.ready;
    // A beat that goes straight through while empty never touches storage.
    assign bypass = FALL_THROUGH && empty && in_if.valid && out_if.ready;
    assign wr_en  = push && !bypass && !flush_i;
    assign rd_en  = pop && !bypass && !flush_i;

    stream_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (flush_i),
      .inc_i (wr_en),
      .ptr_o (wr_ptr)
    );

    stream_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (flush_i),
      .inc_i (rd_en),
      .ptr_o (rd_ptr)
    );

    // NOTE: storage has no reset; only pointers and usage are cleared, and
    // data_o is ignored while valid_o is low.
    always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr] <= in_if.data;
    end

    always_comb begin
      // NOTE: defaulting usage_nxt first keeps every path assigned, so no
      // latch is inferred.
      usage_nxt = usage_q;
      if (flush_i) begin
        usage_nxt = '0;
      end else if (wr_en && !rd_en) begin
        usage_nxt = usage_q + CNT_WIDTH'(1);
      end else if (rd_en && !wr_en) begin
        usage_nxt = usage_q - CNT_WIDTH'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) usage_q <= '0;
      else       usage_q <= usage_nxt;
    end

    assign usage_o        = usage_q;
    assign almost_full_o  = (int'(usage_q) >= AF_THRESH);
    assign almost_empty_o = (int'(usage_q) <= AE_THRESH);

`ifdef STREAM_FIFO_THR_STATS_EN
    stats_t               stats_q;
    logic [CNT_WIDTH-1:0] hwm_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stats_q <= '0;
        hwm_q   <= '0;
      end else begin
        // A flushed cycle completes no handshake; counts survive the flush.
        if (push && !flush_i) stats_q.push_cnt <= stats_q.push_cnt + STATS_CNT_W'(1);
        if (pop && !flush_i)  stats_q.pop_cnt  <= stats_q.pop_cnt + STATS_CNT_W'(1);
        if (flush_i)                hwm_q <= '0;
        else if (usage_nxt > hwm_q) hwm_q <= usage_nxt;
      end
    end
    assign push_cnt_o = stats_q.push_cnt;
    assign pop_cnt_o  = stats_q.pop_cnt;
    assign hwm_o      = hwm_q;
`endif
  end

endmodule

// File: tb/tb_stream_fifo_thr.sv
// tb_stream_fifo_thr: three FIFOs driven by one shared stimulus stream:
//   inst 0: DEPTH=8, FALL_THROUGH=0, AF=7, AE=1
//   inst 1: DEPTH=5, FALL_THROUGH=1, AF=4, AE=1
//   pass  : DEPTH=0 pass-through
// The model keeps an entry count and a queue of expected beats per FIFO.
module tb_stream_fifo_thr;
  typedef logic [31:0] word_t;
  localparam int NI = 2;

  logic  clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst = 1'b1, flush = 1'b0, s_valid = 1'b0, s_ready = 1'b0;
  word_t s_data = '0;

  stream_fifo_thr_if #(.T(word_t)) in_a (), out_a (), in_b (), out_b (), in_z (), out_z ();

  assign in_a.valid  = s_valid;
  assign in_a.data   = s_data;
  assign out_a.ready = s_ready;
  assign in_b.valid  = s_valid;
  assign in_b.data   = s_data;
  assign out_b.ready = s_ready;
  assign in_z.valid  = s_valid;
  assign in_z.data   = s_data;
  assign out_z.ready = s_ready;

  logic [3:0] usage_a;
  logic [2:0] usage_b;
  logic [0:0] usage_z;
  logic af_a, ae_a, af_b, ae_b, af_z, ae_z;
`ifdef STREAM_FIFO_THR_STATS_EN
  logic [31:0] push_cnt_a, pop_cnt_a, push_cnt_b, pop_cnt_b, push_cnt_z, pop_cnt_z;
  logic [3:0]  hwm_a;
  logic [2:0]  hwm_b;
  logic [0:0]  hwm_z;
`endif

  stream_fifo_thr #(.FALL_THROUGH(1'b0), .DEPTH(8), .T(word_t)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .usage_o(usage_a),
    .almost_full_o(af_a), .almost_empty_o(ae_a), .in_if(in_a), .out_if(out_a)
`ifdef STREAM_FIFO_THR_STATS_EN
    , .push_cnt_o(push_cnt_a), .pop_cnt_o(pop_cnt_a), .hwm_o(hwm_a)
`endif
  );

  stream_fifo_thr #(.FALL_THROUGH(1'b1), .DEPTH(5), .T(word_t), .AF_THRESH(4), .AE_THRESH(1)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .usage_o(usage_b),
    .almost_full_o(af_b), .almost_empty_o(ae_b), .in_if(in_b), .out_if(out_b)
`ifdef STREAM_FIFO_THR_STATS_EN
    , .push_cnt_o(push_cnt_b), .pop_cnt_o(pop_cnt_b), .hwm_o(hwm_b)
`endif
  );

  stream_fifo_thr #(.FALL_THROUGH(1'b0), .DEPTH(0), .T(word_t), .AF_THRESH(0), .AE_THRESH(0)) u_z (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .usage_o(usage_z),
    .almost_full_o(af_z), .almost_empty_o(ae_z), .in_if(in_z), .out_if(out_z)
`ifdef STREAM_FIFO_THR_STATS_EN
    , .push_cnt_o(push_cnt_z), .pop_cnt_o(pop_cnt_z), .hwm_o(hwm_z)
`endif
  );

  // Per-FIFO views so the monitor can loop over instances.
  int    dut_usage [NI];
  logic  dut_valid [NI], dut_ready [NI], dut_af [NI], dut_ae [NI];
  word_t dut_data  [NI];
  assign dut_usage[0] = int'(usage_a);
  assign dut_usage[1] = int'(usage_b);
  assign dut_valid[0] = out_a.valid;
  assign dut_valid[1] = out_b.valid;
  assign dut_ready[0] = in_a.ready;
  assign dut_ready[1] = in_b.ready;
  assign dut_af[0]    = af_a;
  assign dut_af[1]    = af_b;
  assign dut_ae[0]    = ae_a;
  assign dut_ae[1]    = ae_b;
  assign dut_data[0]  = out_a.data;
  assign dut_data[1]  = out_b.data;

  function automatic int dep(input int k);  return (k == 0) ? 8 : 5; endfunction
  function automatic bit ft(input int k);   return (k == 1);         endfunction
  function automatic int afth(input int k); return (k == 0) ? 7 : 4; endfunction
  function automatic int aeth(input int k); return 1;                endfunction

  // Reference model state (value seen during the current cycle).
  int          m_cnt [NI];
  word_t       exp_q [NI][$];
  logic [31:0] m_push = '0, m_pop = '0;
  int          m_hwm = 0;

  int   checks = 0, errors = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples at the falling edge, when inputs and outputs are settled.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        check($sformatf("valid[%0d]", k), 64'(dut_valid[k]),
              64'((m_cnt[k] > 0) || (ft(k) && s_valid)));
        check($sformatf("ready[%0d]", k), 64'(dut_ready[k]), 64'(m_cnt[k] != dep(k)));
        check($sformatf("usage[%0d]", k), 64'(dut_usage[k]), 64'(m_cnt[k]));
        check($sformatf("almost_full[%0d]", k), 64'(dut_af[k]), 64'(m_cnt[k] >= afth(k)));
        check($sformatf("almost_empty[%0d]", k), 64'(dut_ae[k]), 64'(m_cnt[k] <= aeth(k)));
        if (dut_valid[k] && s_ready) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop[%0d]: got beat %0h, expected none (t=%0t)", k, dut_data[k], $time);
          end else begin
            check($sformatf("pop_data[%0d]", k), 64'(dut_data[k]), 64'(exp_q[k].pop_front()));
          end
        end
      end
      check("pass_valid", 64'(out_z.valid), 64'(s_valid));
      check("pass_ready", 64'(in_z.ready), 64'(s_ready));
      check("pass_data", 64'(out_z.data), 64'(s_data));
      check("pass_usage", 64'(usage_z), 64'(0));
      check("pass_flags", 64'({af_z, ae_z}), 64'(2'b11));
`ifdef STREAM_FIFO_THR_STATS_EN
      check("push_cnt", 64'(push_cnt_a), 64'(m_push));
      check("pop_cnt", 64'(pop_cnt_a), 64'(m_pop));
      check("hwm", 64'(hwm_a), 64'(m_hwm));
`endif
    end
  end

  // Drive one cycle of stimulus and advance the model across the next edge.
  // The consumer never accepts on a flush or reset cycle.
  task automatic step(input logic v, input word_t d, input logic r, input logic f, input logic rs);
    logic        re, clr, push, pop, push0, pop0;
    int          nxt [NI];
    logic [31:0] np, nq;
    int          nh;
    re  = r & ~f & ~rs;
    clr = f | rs;
    s_valid = v;
    s_data  = d;
    s_ready = re;
    flush   = f;
    rst     = rs;
    push0 = 1'b0;
    pop0  = 1'b0;
    for (int k = 0; k < NI; k++) begin
      push = v && (m_cnt[k] != dep(k));
      pop  = re && ((m_cnt[k] > 0) || (ft(k) && v));
      if (k == 0) begin
        push0 = push;
        pop0  = pop;
      end
      if (clr) begin
        nxt[k] = 0;
      end else begin
        if (push) exp_q[k].push_back(d);
        nxt[k] = m_cnt[k] + int'(push) - int'(pop);
      end
    end
    np = m_push;
    nq = m_pop;
    nh = m_hwm;
    if (rs) begin
      np = '0;
      nq = '0;
      nh = 0;
    end else if (f) begin
      nh = 0;
    end else begin
      np = np + 32'(push0);
      nq = nq + 32'(pop0);
      if (nxt[0] > nh) nh = nxt[0];
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      m_cnt[k] = nxt[k];
      if (clr) exp_q[k].delete();
    end
    m_push = np;
    m_pop  = nq;
    m_hwm  = nh;
    #1;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) m_cnt[k] = 0;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;

    // Fill with the consumer stalled: beats 0x1..0x8.
    for (int i = 1; i <= 8; i++) step(1'b1, word_t'(i), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Full, both sides active: pop-only first, then push+pop together.
    for (int i = 9; i <= 14; i++) step(1'b1, word_t'(i), 1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Fall-through on an empty FIFO.
    step(1'b1, 32'hAB, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Four entries, then flush together with a push of 0xCC.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h10 + word_t'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hCC, 1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // From reset: 10 pushes, 6 pops, then flush.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h20 + word_t'(i), (i >= 4), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a burst.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h30 + word_t'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDD, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Random traffic: a slow consumer first (fills and wraps), then a fast one.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), word_t'($urandom),
           (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 149) == 0));
    end
    repeat (10) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
